// File: rtl/mmtx_pkg.sv
// Shared definitions for the mmtx transmit packet buffer.
package mmtx_pkg;

    localparam int unsigned WORD_W  = 18;
    localparam int unsigned SOP_BIT = 17;
    localparam int unsigned EOP_BIT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/mmtx_dpram.sv
// Simple dual-port word RAM with a registered read port; the read register clears on reset.
module mmtx_dpram
    import mmtx_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk_12_5m,
    input  logic              rst_12_5m,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_12_5m) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value between reads
    always_ff @(posedge clk_12_5m) begin
        if (!rst_12_5m) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mmtx.sv
// Store-and-forward transmit buffer: packets become readable only once their eop word is stored.
module mmtx
    import mmtx_pkg::*;
#(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_12_5m,
    input  logic              rst_12_5m,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              wr_full,
    input  logic              mactx_mmtx_rdreq,
    output logic [WORD_W-1:0] mmtx_mactx_data,
    output logic              mmtx_mactx_dval,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    wr_state_e         state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] ram_waddr;
    logic              ram_we;
    logic              commit;
    logic              drop;
    logic              rd_fire;
    logic              eop_read;
    logic              full_d;
    logic [CNT_W-1:0]  pkt_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_d;
    logic              in_sop;
    logic              in_eop;

    assign in_sop = wr_data[SOP_BIT];
    assign in_eop = wr_data[EOP_BIT];

    always_ff @(posedge clk_12_5m) begin
        if (!rst_12_5m) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write FSM: pointer moves, commits and whole-packet discards
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        ram_we       = 1'b0;
        ram_waddr    = wr_ptr_q[ADDR_W-1:0];
        commit       = 1'b0;
        drop         = 1'b0;
        if (wr_en) begin
            unique case (state_q)
                ST_IDLE, ST_DROP: begin
                    if (in_sop) begin
                        if (wr_full) begin
                            drop    = 1'b1;
                            state_d = in_eop ? ST_IDLE : ST_DROP;
                        end else begin
                            ram_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                            if (in_eop) begin
                                commit       = 1'b1;
                                commit_ptr_d = wr_ptr_q + PTR_W'(1);
                                state_d      = ST_IDLE;
                            end else begin
                                state_d = ST_PKT;
                            end
                        end
                    end else if (state_q == ST_DROP && in_eop) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PKT: begin
                    if (in_sop) begin
                        // Missing eop: discard the open packet and restart at the commit point
                        drop      = 1'b1;
                        ram_we    = 1'b1;
                        ram_waddr = commit_ptr_q[ADDR_W-1:0];
                        wr_ptr_d  = commit_ptr_q + PTR_W'(1);
                        if (in_eop) begin
                            commit       = 1'b1;
                            commit_ptr_d = commit_ptr_q + PTR_W'(1);
                            state_d      = ST_IDLE;
                        end else begin
                            state_d = ST_PKT;
                        end
                    end else if (wr_full) begin
                        drop     = 1'b1;
                        wr_ptr_d = commit_ptr_q;
                        state_d  = in_eop ? ST_IDLE : ST_DROP;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        if (in_eop) begin
                            commit       = 1'b1;
                            commit_ptr_d = wr_ptr_q + PTR_W'(1);
                            state_d      = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Reads are blocked while dval is high so the eop decrement lands before the next read
    assign rd_fire  = mactx_mmtx_rdreq && (pkt_cnt != '0) && !mmtx_mactx_dval;
    assign eop_read = mmtx_mactx_dval && mmtx_mactx_data[EOP_BIT];
    assign rd_ptr_d = rd_ptr_q + PTR_W'(rd_fire);
    assign full_d   = (wr_ptr_d - rd_ptr_d) == PTR_W'(DEPTH);

    always_comb begin
        pkt_cnt_d = pkt_cnt;
        unique case ({commit, eop_read})
            2'b10:   pkt_cnt_d = pkt_cnt + CNT_W'(1);
            2'b01:   pkt_cnt_d = pkt_cnt - CNT_W'(1);
            default: pkt_cnt_d = pkt_cnt;
        endcase
    end

    assign drop_cnt_d = (drop && (drop_cnt != '1)) ? drop_cnt + CNT_W'(1) : drop_cnt;

    always_ff @(posedge clk_12_5m) begin
        if (!rst_12_5m) begin
            wr_ptr_q        <= '0;
            commit_ptr_q    <= '0;
            rd_ptr_q        <= '0;
            wr_full         <= 1'b0;
            mmtx_mactx_dval <= 1'b0;
            pkt_cnt         <= '0;
            drop_cnt        <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            commit_ptr_q    <= commit_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_full         <= full_d;
            mmtx_mactx_dval <= rd_fire;
            pkt_cnt         <= pkt_cnt_d;
            drop_cnt        <= drop_cnt_d;
        end
    end

    mmtx_dpram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_12_5m (clk_12_5m),
        .rst_12_5m (rst_12_5m),
        .we        (ram_we),
        .waddr     (ram_waddr),
        .wdata     (wr_data),
        .re        (rd_fire),
        .raddr     (rd_ptr_q[ADDR_W-1:0]),
        .rdata     (mmtx_mactx_data)
    );

endmodule
